memwb_stage: RTL and testbench



---
 rtl/memwb_stage.sv | 161 ++++++++++++++++
 tb/tb_memwb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, one-entry skid buffer, flush and sync reset.
// Optional forwarding outputs (fwd_valid/fwd_reg/fwd_data) are enabled by defining MEMWB_FWD_EN.
module memwb_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic [RWIDTH-1:0] regdstmuxin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] dmdatain,
    input  logic [AWIDTH-1:0] pcnextin,
    input  logic              negativein,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        memtoregout,
    output logic [RWIDTH-1:0] regdstmuxout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] dmdataout,
    output logic [AWIDTH-1:0] pcnextout,
    output logic              negativeout,
    output logic              regwrout,
    output logic [DWIDTH-1:0] wbdata
`ifdef MEMWB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [RWIDTH-1:0] fwd_reg,
    output logic [DWIDTH-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]        memtoreg;
        logic              regwr;
        logic [RWIDTH-1:0] regdst;
        logic [DWIDTH-1:0] aluout;
        logic [DWIDTH-1:0] dmdata;
        logic [AWIDTH-1:0] pcnext;
        logic              negative;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;
    logic [DWIDTH-1:0] pc_ext;

    assign in_entry = '{memtoreg: memtoregin, regwr: regwrin, regdst: regdstmuxin,
                        aluout: aluoutin, dmdata: dmdatain, pcnext: pcnextin,
                        negative: negativein};

    // Handshake flags decode the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and storage-update logic for the main/skid pair.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry;
                end else if (in_fire) begin
                    skid_d  = in_entry;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Reset clears everything; flush only drops validity and keeps stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (AWIDTH >= DWIDTH) begin : g_pc_trunc
            assign pc_ext = main_q.pcnext[DWIDTH-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DWIDTH-AWIDTH){1'b0}}, main_q.pcnext};
        end
    endgenerate

    // Write-back source select on the head entry.
    always_comb begin
        wbdata = {DWIDTH{1'b0}};
        case (main_q.memtoreg)
            2'b00:   wbdata = main_q.aluout;
            2'b01:   wbdata = main_q.dmdata;
            2'b10:   wbdata = pc_ext;
            2'b11:   wbdata = {{(DWIDTH-1){1'b0}}, main_q.negative};
            default: wbdata = {DWIDTH{1'b0}};
        endcase
    end

    assign memtoregout  = main_q.memtoreg;
    assign regdstmuxout = main_q.regdst;
    assign aluoutout    = main_q.aluout;
    assign dmdataout    = main_q.dmdata;
    assign pcnextout    = main_q.pcnext;
    assign negativeout  = main_q.negative;
    assign regwrout     = main_q.regwr & out_valid & (main_q.regdst != {RWIDTH{1'b0}});

`ifdef MEMWB_FWD_EN
    assign fwd_valid = regwrout;
    assign fwd_reg   = main_q.regdst;
    assign fwd_data  = wbdata;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed self-checking bench for memwb_stage; forwarding checks run when MEMWB_FWD_EN is defined.
module tb_memwb_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  memtoregin, memtoregout;
    logic        regwrin, negativein, negativeout, regwrout;
    logic [4:0]  regdstmuxin, regdstmuxout;
    logic [31:0] aluoutin, dmdatain, pcnextin;
    logic [31:0] aluoutout, dmdataout, pcnextout, wbdata;
`ifdef MEMWB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    memwb_stage #(.DWIDTH(32), .AWIDTH(32), .RWIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .memtoregin(memtoregin), .regwrin(regwrin), .regdstmuxin(regdstmuxin),
        .aluoutin(aluoutin), .dmdatain(dmdatain), .pcnextin(pcnextin),
        .negativein(negativein),
        .out_valid(out_valid), .out_ready(out_ready),
        .memtoregout(memtoregout), .regdstmuxout(regdstmuxout),
        .aluoutout(aluoutout), .dmdataout(dmdataout), .pcnextout(pcnextout),
        .negativeout(negativeout), .regwrout(regwrout), .wbdata(wbdata)
`ifdef MEMWB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m2r, input logic wr,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] pc, input logic neg);
        in_valid    = v;
        memtoregin  = m2r;
        regwrin     = wr;
        regdstmuxin = rd;
        aluoutin    = alu;
        dmdatain    = dm;
        pcnextin    = pc;
        negativein  = neg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 5'd9, 32'h99, 32'h1234, 32'h800, 1'b1);

        // Reset held two cycles with valid input present
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_regwrout", {31'd0, regwrout}, 32'd0);
        check("rst_wbdata", wbdata, 32'd0);
        check("rst_aluout", aluoutout, 32'd0);
        check("rst_dmdata", dmdataout, 32'd0);
        check("rst_pcnext", pcnextout, 32'd0);
        check("rst_regdst", {27'd0, regdstmuxout}, 32'd0);
        check("rst_m2r_neg", {29'd0, memtoregout, negativeout}, 32'd0);

        // First input after reset
        rst = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 5'd3, 32'h10, 32'h0, 32'h0, 1'b0);
        tick();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_wbdata", wbdata, 32'h10);
        check("first_regwr", {31'd0, regwrout}, 32'd1);

        // Streaming: 8 back-to-back, one per cycle, in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b00, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0);
            tick();
            check("stream_data", aluoutout, 32'h100 + 32'(i));
            check("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Stall/skid: A, B fill both entries; C is held off
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 5'd1, 32'h1, 32'h0, 32'h0, 1'b0);
        tick();
        check("skid_a_head", aluoutout, 32'h1);
        drive(1'b1, 2'b00, 1'b1, 5'd1, 32'h2, 32'h0, 32'h0, 1'b0);
        tick();
        check("skid_two_ready", {31'd0, in_ready}, 32'd0);
        check("skid_two_head", aluoutout, 32'h1);
        drive(1'b1, 2'b00, 1'b1, 5'd1, 32'h3, 32'h0, 32'h0, 1'b0);
        tick();
        check("skid_hold_head", aluoutout, 32'h1);
        check("skid_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("skid_b_out", aluoutout, 32'h2);
        check("skid_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("skid_c_out", aluoutout, 32'h3);
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("skid_drain", {31'd0, out_valid}, 32'd0);

        // Flush while TWO with a valid input present
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 5'd4, 32'h20, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 1'b1, 5'd4, 32'h21, 32'h0, 32'h0, 1'b0);
        tick();
        check("flush_pre_two", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 5'd4, 32'h22, 32'h0, 32'h0, 1'b0);
        tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        check("flush_regwr", {31'd0, regwrout}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("flush_no_replay", {31'd0, out_valid}, 32'd0);

        // Write-back source select and register 0 suppression
        drive(1'b1, 2'b01, 1'b1, 5'd5, 32'h77, 32'hDEADBEEF, 32'h0, 1'b0);
        tick();
        check("wb_dmdata", wbdata, 32'hDEADBEEF);
        check("wb_dm_regwr", {31'd0, regwrout}, 32'd1);
        drive(1'b1, 2'b11, 1'b1, 5'd6, 32'h77, 32'h0, 32'h0, 1'b1);
        tick();
        check("wb_slt_one", wbdata, 32'd1);
        drive(1'b1, 2'b11, 1'b1, 5'd6, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        tick();
        check("wb_slt_zero", wbdata, 32'd0);
        drive(1'b1, 2'b10, 1'b1, 5'd31, 32'h77, 32'h0, 32'h404, 1'b0);
        tick();
        check("wb_pcnext", wbdata, 32'h404);
        drive(1'b1, 2'b00, 1'b1, 5'd0, 32'h5, 32'h0, 32'h0, 1'b0);
        tick();
        check("wb_r0_regwr", {31'd0, regwrout}, 32'd0);
        check("wb_r0_data", wbdata, 32'h5);
        drive(1'b1, 2'b00, 1'b0, 5'd9, 32'h6, 32'h0, 32'h0, 1'b0);
        tick();
        check("wb_nowr_regwr", {31'd0, regwrout}, 32'd0);

`ifdef MEMWB_FWD_EN
        drive(1'b1, 2'b00, 1'b1, 5'd7, 32'h55, 32'h0, 32'h0, 1'b0);
        tick();
        check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("fwd_reg", {27'd0, fwd_reg}, 32'd7);
        check("fwd_data", fwd_data, 32'h55);
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("fwd_retired", {31'd0, fwd_valid}, 32'd0);
`endif

        // Reset while TWO: both entries lost, nothing replayed
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 5'd2, 32'h30, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 1'b1, 5'd2, 32'h31, 32'h0, 32'h0, 1'b0);
        tick();
        check("rst2_pre_two", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_alu", aluoutout, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("rst2_no_replay", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
